// File: rtl/dac_pkg.sv
// Shared definitions for the LTC2624 DAC SPI interface: word geometry,
// command/address codes, field positions and the transmitter FSM state type.
package dac_pkg;

    localparam int unsigned DAC_WORD_W = 32;
    localparam int unsigned DAC_DATA_W = 12;

    // LTC2624 command codes
    localparam logic [3:0] CMD_WRITE        = 4'b0000;
    localparam logic [3:0] CMD_UPDATE       = 4'b0001;
    localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;
    localparam logic [3:0] CMD_PWRDN        = 4'b0100;

    // LTC2624 channel addresses
    localparam logic [3:0] ADDR_A   = 4'b0000;
    localparam logic [3:0] ADDR_B   = 4'b0001;
    localparam logic [3:0] ADDR_C   = 4'b0010;
    localparam logic [3:0] ADDR_D   = 4'b0011;
    localparam logic [3:0] ADDR_ALL = 4'b1111;

    // Field LSB positions in the 32-bit word {8'h00, cmd, addr, data, 4'h0}
    localparam int unsigned CMD_LSB  = 20;
    localparam int unsigned ADDR_LSB = 16;
    localparam int unsigned DATA_LSB = 4;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StHold,
        StGap
    } dac_state_e;

    function automatic logic [DAC_WORD_W-1:0] dac_frame(
        input logic [3:0]            cmd,
        input logic [3:0]            addr,
        input logic [DAC_DATA_W-1:0] code
    );
        logic [DAC_WORD_W-1:0] w;
        w                        = '0;
        w[CMD_LSB +: 4]          = cmd;
        w[ADDR_LSB +: 4]         = addr;
        w[DATA_LSB +: DAC_DATA_W] = code;
        return w;
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK generator: CLKDIV-cycle half-period counter with one-cycle strobes.
// The counter runs whenever 'run' is high so the caller can also time the
// CS hold and gap phases; SCK itself only toggles while 'sck_en' is high.
module spi_sck_gen
    import dac_pkg::*;
#(
    parameter int unsigned CLKDIV = 2
) (
    input  logic CLK50MHZ,
    input  logic RST,
    input  logic run,
    input  logic sck_en,
    output logic tick,
    output logic rise_tick,
    output logic fall_tick,
    output logic sck
);

    localparam logic [7:0] LastCnt = 8'(CLKDIV - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       sck_q, sck_d;

    // Strobes are high in the cycle before the edge on which SCK changes
    assign tick      = run && (cnt_q == LastCnt);
    assign rise_tick = tick && sck_en && !sck_q;
    assign fall_tick = tick && sck_en && sck_q;
    assign sck       = sck_q;

    // Next-state for the half-period counter and SCK level
    always_comb begin
        cnt_d = 8'd0;
        sck_d = sck_q;
        if (run && !tick) begin
            cnt_d = cnt_q + 8'd1;
        end
        if (!sck_en) begin
            sck_d = 1'b0;
        end else if (tick) begin
            sck_d = ~sck_q;
        end
    end

    // Counter and SCK registers
    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            cnt_q <= 8'd0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

endmodule

// File: rtl/dac_spi_master.sv
// LTC2624 SPI transmitter: serialises one 32-bit word MSB-first per dactrig
// and returns the word echoed on SPI_MISO.
// Build option: define DAC_SPI_READBACK_EN to include the receive path;
// otherwise dac_datareceived is tied to zero and SPI_MISO is ignored.
module dac_spi_master
    import dac_pkg::*;
#(
    parameter int unsigned CLKDIV = 2
) (
    input  logic                  CLK50MHZ,
    input  logic                  RST,
    input  logic [DAC_DATA_W-1:0] data,
    input  logic [3:0]            address,
    input  logic [3:0]            command,
    input  logic                  dactrig,
    output logic                  dacdone,
    output logic                  busy,
    output logic [DAC_WORD_W-1:0] dac_datareceived,
    output logic                  SPI_MOSI,
    output logic                  SPI_SCK,
    output logic                  DAC_CS,
    output logic                  DAC_CLR,
    input  logic                  SPI_MISO
);

    dac_state_e            state_q, state_d;
    logic [DAC_WORD_W-1:0] tx_q;
    logic [4:0]            bit_cnt_q;
    logic                  bit_last;
    logic                  done_q;
    logic                  clr_q;
    logic                  accept;
    logic                  sck_run, sck_en;
    logic                  tick, rise_tick, fall_tick;

    assign accept   = (state_q == StIdle) && dactrig;
    assign bit_last = (bit_cnt_q == 5'd31);
    assign sck_run  = (state_q != StIdle);
    assign sck_en   = (state_q == StShift);

    spi_sck_gen #(
        .CLKDIV (CLKDIV)
    ) u_sck_gen (
        .CLK50MHZ  (CLK50MHZ),
        .RST       (RST),
        .run       (sck_run),
        .sck_en    (sck_en),
        .tick      (tick),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .sck       (SPI_SCK)
    );

    // State register
    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; HOLD and GAP each last one half-period tick
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (dactrig) state_d = StShift;
            StShift: if (fall_tick && bit_last) state_d = StHold;
            StHold:  if (tick) state_d = StGap;
            StGap:   if (tick) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        DAC_CS   = 1'b1;
        busy     = (state_q != StIdle);
        SPI_MOSI = 1'b0;
        if ((state_q == StShift) || (state_q == StHold)) begin
            DAC_CS = 1'b0;
        end
        if (state_q == StShift) begin
            SPI_MOSI = tx_q[DAC_WORD_W-1];
        end
    end

    // Transmit shift register, bit counter, done pulse and clear release
    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            tx_q      <= '0;
            bit_cnt_q <= 5'd0;
            done_q    <= 1'b0;
            clr_q     <= 1'b0;
        end else begin
            clr_q  <= 1'b1;
            done_q <= (state_q == StHold) && tick;
            if (accept) begin
                tx_q      <= dac_frame(command, address, data);
                bit_cnt_q <= 5'd0;
            end else if (fall_tick) begin
                tx_q <= {tx_q[DAC_WORD_W-2:0], 1'b0};
                // Terminal count moves the FSM on; never roll into a 33rd bit
                if (!bit_last) begin
                    bit_cnt_q <= bit_cnt_q + 5'd1;
                end
            end
        end
    end

    assign dacdone = done_q;
    assign DAC_CLR = clr_q;

`ifdef DAC_SPI_READBACK_EN
    logic [DAC_WORD_W-1:0] rx_q;
    logic [DAC_WORD_W-1:0] rx_word_q;

    // Receive shift register samples MISO on the edge SCK rises
    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            rx_q      <= '0;
            rx_word_q <= '0;
        end else begin
            if (rise_tick) begin
                rx_q <= {rx_q[DAC_WORD_W-2:0], SPI_MISO};
            end
            if ((state_q == StHold) && tick) begin
                rx_word_q <= rx_q;
            end
        end
    end

    assign dac_datareceived = rx_word_q;
`else
    logic unused_rx;
    assign unused_rx        = SPI_MISO ^ rise_tick;
    assign dac_datareceived = '0;
`endif

endmodule

// File: tb/tb_dac_spi_master.sv
// Bench for dac_spi_master: three instances (CLKDIV 1, 2, 255) share inputs;
// each observed frame is compared against a timeline derived from CLKDIV.
module tb_dac_spi_master;
    import dac_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        dactrig;
    logic        miso;
    logic [11:0] data;
    logic [3:0]  address;
    logic [3:0]  command;

    logic [2:0]  cs, sck, mosi, done, busy, clr;
    logic [31:0] rx [3];

    always #10 clk = ~clk;

    dac_spi_master #(.CLKDIV(1)) u_div1 (
        .CLK50MHZ(clk), .RST(rst), .data(data), .address(address), .command(command),
        .dactrig(dactrig), .dacdone(done[0]), .busy(busy[0]), .dac_datareceived(rx[0]),
        .SPI_MOSI(mosi[0]), .SPI_SCK(sck[0]), .DAC_CS(cs[0]), .DAC_CLR(clr[0]),
        .SPI_MISO(miso)
    );
    dac_spi_master #(.CLKDIV(2)) u_div2 (
        .CLK50MHZ(clk), .RST(rst), .data(data), .address(address), .command(command),
        .dactrig(dactrig), .dacdone(done[1]), .busy(busy[1]), .dac_datareceived(rx[1]),
        .SPI_MOSI(mosi[1]), .SPI_SCK(sck[1]), .DAC_CS(cs[1]), .DAC_CLR(clr[1]),
        .SPI_MISO(miso)
    );
    dac_spi_master #(.CLKDIV(255)) u_div255 (
        .CLK50MHZ(clk), .RST(rst), .data(data), .address(address), .command(command),
        .dactrig(dactrig), .dacdone(done[2]), .busy(busy[2]), .dac_datareceived(rx[2]),
        .SPI_MOSI(mosi[2]), .SPI_SCK(sck[2]), .DAC_CS(cs[2]), .DAC_CLR(clr[2]),
        .SPI_MISO(miso)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Word the modelled DAC echoes on MISO during the next frame
    logic [31:0] echo_word;

    // Per-frame observations
    int          t_done, n_done, n_cs_low, t_idle, n_rises, sck_bad, rx_bad, hp_min, hp_max;
    logic [31:0] word_tx;

    typedef struct {
        logic [11:0] d;
        logic [3:0]  a;
        logic [3:0]  c;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference word: command*2^20 + address*2^16 + data*16
    function automatic logic [31:0] model_word(input logic [3:0] c, input logic [3:0] a,
                                               input logic [11:0] d);
        return 32'(c) * 32'h0010_0000 + 32'(a) * 32'h0001_0000 + 32'(d) * 32'd16;
    endfunction

    // Present a request; returns right after the accepting edge E0
    task automatic start(input logic [11:0] d, input logic [3:0] a, input logic [3:0] c);
        @(negedge clk);
        data    = d;
        address = a;
        command = c;
        dactrig = 1'b1;
        @(posedge clk);
    endtask

    // Observe instance idx from E0 until busy drops; t = samples after edge E0+t.
    // p1/p2 pulse dactrig so it is seen on edge E0+p1 / E0+p2 (-1 = none).
    task automatic capture(input int idx, input int c, input int p1, input int p2);
        logic        prev_sck;
        logic [31:0] prev_rx;
        int          last_tog, hp;
        prev_sck = 1'b0;
        prev_rx  = '0;
        last_tog = 0;
        t_done   = -1;
        t_idle   = -1;
        n_done   = 0;
        n_cs_low = 0;
        n_rises  = 0;
        sck_bad  = 0;
        rx_bad   = 0;
        hp_min   = 1 << 30;
        hp_max   = 0;
        word_tx  = '0;
        for (int t = 0; t < 66 * c + 20; t++) begin
            @(negedge clk);
            dactrig = (t == p1 - 1) || (t == p2 - 1);
            if (t == 1) begin
                data    = 12'($urandom);
                address = 4'($urandom);
                command = 4'($urandom);
            end
            if (sck[idx] !== prev_sck) begin
                if (cs[idx]) sck_bad++;
                hp = t - last_tog;
                if (hp < hp_min) hp_min = hp;
                if (hp > hp_max) hp_max = hp;
                last_tog = t;
                if (sck[idx]) begin
                    n_rises++;
                    word_tx = {word_tx[30:0], mosi[idx]};
                end
            end
            if (!cs[idx]) n_cs_low++;
            if (done[idx]) begin
                n_done++;
                if (t_done < 0) t_done = t;
            end
            if (t > 0 && rx[idx] !== prev_rx && !done[idx]) rx_bad++;
            prev_rx  = rx[idx];
            prev_sck = sck[idx];
            miso     = (n_rises < 32) ? echo_word[31 - n_rises] : 1'b0;
            if (t > 0 && !busy[idx]) begin
                t_idle = t;
                break;
            end
        end
    endtask

    task automatic do_frame(input int idx, input int c, input logic [11:0] d,
                            input logic [3:0] a, input logic [3:0] cmd, input logic [31:0] exp,
                            input int p1, input int p2);
        logic [31:0] exp_rx;
`ifdef DAC_SPI_READBACK_EN
        exp_rx = echo_word;
`else
        exp_rx = 32'h0;
`endif
        start(d, a, cmd);
        capture(idx, c, p1, p2);
        check("mosi_word", word_tx, exp);
        check("sck_rises", n_rises, 32);
        check("done_time", t_done, 65 * c);
        check("done_count", n_done, 1);
        check("cs_low_cycles", n_cs_low, 65 * c);
        check("busy_low_time", t_idle, 66 * c);
        check("sck_half_min", hp_min, c);
        check("sck_half_max", hp_max, c);
        check("sck_while_cs_high", sck_bad, 0);
        check("rx_changed_early", rx_bad, 0);
        check("datareceived", rx[idx], exp_rx);
        echo_word = exp;
    endtask

    initial begin
        int n_exp, frames, rises, gap_run, min_gap, seen_low, t_end;
        logic [11:0] rd;
        logic [3:0]  ra, rc;

        tbl[0] = '{12'hABC, ADDR_ALL, CMD_WRITE_UPDATE, 32'h003F_ABC0};
        tbl[1] = '{12'h123, ADDR_ALL, CMD_WRITE_UPDATE, 32'h003F_1230};
        tbl[2] = '{12'h456, ADDR_ALL, CMD_WRITE_UPDATE, 32'h003F_4560};
        tbl[3] = '{12'hFFF, ADDR_B,   CMD_WRITE,        32'h0001_FFF0};
        tbl[4] = '{12'h000, ADDR_ALL, CMD_PWRDN,        32'h004F_0000};

        rst       = 1'b1;
        dactrig   = 1'b0;
        miso      = 1'b0;
        data      = '0;
        address   = '0;
        command   = '0;
        echo_word = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_cs", cs, 3'b111);
        check("rst_sck", sck, 3'b000);
        check("rst_mosi", mosi, 3'b000);
        check("rst_done", done, 3'b000);
        check("rst_busy", busy, 3'b000);
        check("rst_clr", clr, 3'b000);
        check("rst_rx", rx[1], 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("clr_release", clr, 3'b111);

        // Table-driven frames at CLKDIV=2
        for (int i = 0; i < 5; i++) begin
            do_frame(1, 2, tbl[i].d, tbl[i].a, tbl[i].c, tbl[i].exp, -1, -1);
        end

        // Triggers during a frame are ignored
        do_frame(1, 2, 12'h5A5, ADDR_C, CMD_WRITE_UPDATE, 32'h0032_5A50, 10, 131);
        frames = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (busy[1] || done[1]) frames++;
        end
        check("no_extra_frame", frames, 0);

        // Randomised frames against the arithmetic word model
        for (int i = 0; i < 6; i++) begin
            rd = 12'($urandom);
            ra = 4'($urandom_range(0, 15));
            rc = 4'($urandom_range(0, 15));
            do_frame(1, 2, rd, ra, rc, model_word(rc, ra, rd), -1, -1);
        end

        // dactrig held high for 400 edges: back-to-back frames
        n_exp = 0;
        for (int e = 0; e < 400; e += 66 * 2 + 1) n_exp++;
        miso     = 1'b0;
        frames   = 0;
        rises    = 0;
        gap_run  = 0;
        min_gap  = 1 << 30;
        seen_low = 0;
        t_end    = -1;
        @(negedge clk);
        dactrig = 1'b1;
        for (int t = 0; t < 1000; t++) begin
            logic psck;
            psck = sck[1];
            @(negedge clk);
            if (t == 399) dactrig = 1'b0;
            if (sck[1] && !psck) rises++;
            if (done[1]) frames++;
            if (cs[1]) begin
                gap_run++;
            end else begin
                if (seen_low && gap_run > 0 && gap_run < min_gap) min_gap = gap_run;
                gap_run  = 0;
                seen_low = 1;
            end
            if (t > 399 && !busy[1]) begin
                t_end = t;
                break;
            end
        end
        check("held_terminated", (t_end > 0), 1'b1);
        check("held_frames", frames, n_exp);
        check("held_rises", rises, 32 * n_exp);
        check("held_cs_gap", min_gap, 3);
        echo_word = '0;

        // Leave a non-zero received word, then reset mid-frame at E0+50
        echo_word = 32'hCAFE_1234;
        do_frame(1, 2, 12'h777, ADDR_D, CMD_WRITE_UPDATE, 32'h0033_7770, -1, -1);
        start(12'h999, ADDR_ALL, CMD_WRITE_UPDATE);
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            dactrig = 1'b0;
            if (t == 49) rst = 1'b1;
        end
        @(negedge clk);
        check("abort_cs", cs[1], 1'b1);
        check("abort_sck", sck[1], 1'b0);
        check("abort_mosi", mosi[1], 1'b0);
        check("abort_busy", busy[1], 1'b0);
        check("abort_done", done[1], 1'b0);
        check("abort_rx", rx[1], 32'h0);
        check("abort_clr", clr[1], 1'b0);
        rst    = 1'b0;
        frames = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (done[1] || busy[1]) frames++;
        end
        check("abort_quiet", frames, 0);
        echo_word = 32'h0F0F_A5A5;
        do_frame(1, 2, 12'hABC, ADDR_ALL, CMD_WRITE_UPDATE, 32'h003F_ABC0, -1, -1);

        // CLKDIV extremes
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_frame(0, 1, 12'h3C5, ADDR_A, CMD_UPDATE, 32'h0010_3C50, -1, -1);
        t_end = -1;
        for (int t = 0; t < 20000; t++) begin
            @(negedge clk);
            if (!busy[2]) begin
                t_end = t;
                break;
            end
        end
        check("div255_idle_wait", (t_end >= 0), 1'b1);
        do_frame(2, 255, 12'hE1D, ADDR_ALL, CMD_WRITE_UPDATE, 32'h003F_E1D0, -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dac_spi_master.md
Name: dac_spi_master

Overview:
SPI transmitter for the LTC2624 quad 12-bit DAC on the Spartan-3E starter kit. It is the far end of the DAC control interface.
- An upstream controller presents data/address/command and pulses dactrig.
- This block serialises one 32-bit LTC2624 word MSB-first on SPI_MOSI/SPI_SCK with DAC_CS framing.
- It captures the echoed word from SPI_MISO and returns it on dac_datareceived with a one-cycle dacdone pulse.

Parameters:
CLKDIV, 2, CLK50MHZ cycles per SCK half-period; legal range 1..255 (2 gives 12.5 MHz SCK).

Ports:
CLK50MHZ  input  1  system clock, 50 MHz
RST  input  1  reset; synchronous, active-high
data  input  12  DAC code
address  input  4  LTC2624 address (4'b1111 = all channels)
command  input  4  LTC2624 command (4'b0011 = write and update)
dactrig  input  1  start request, sampled only in IDLE
dacdone  output  1  one-cycle pulse when a frame completes
busy  output  1  high from trigger acceptance until ready for the next trigger
dac_datareceived  output  32  word shifted in from SPI_MISO during the last frame
SPI_MOSI  output  1  serial data to DAC
SPI_SCK  output  1  serial clock, idle low
DAC_CS  output  1  chip select, active low
DAC_CLR  output  1  DAC asynchronous clear, active low
SPI_MISO  input  1  DAC serial echo

Behaviour:
- Reset values: DAC_CS=1, SPI_SCK=0, SPI_MOSI=0, dacdone=0, busy=0, dac_datareceived=0, DAC_CLR=0.
- DAC_CLR goes to 1 on the first edge after RST deasserts.
- Frame word = {8'h00, command, address, data, 4'h0}. It is latched into the shift register on acceptance, so later input changes do not affect the frame in flight.
- FSM states: IDLE, SHIFT, HOLD, GAP.
- IDLE: on edge E0 with dactrig=1, latch the word and go to SHIFT. After E0: DAC_CS=0, SPI_MOSI=bit31, SPI_SCK=0, busy=1.
- SHIFT, per bit k=0..31:
  - at E0+(2k+1)*CLKDIV: SPI_SCK rises; SPI_MISO is sampled into the receive shift register (LSB in, shift left) at this same edge.
  - at E0+(2k+2)*CLKDIV: SPI_SCK falls; SPI_MOSI presents the next bit.
  - After the 32nd falling edge (E0+64*CLKDIV), go to HOLD. SPI_MOSI is driven 0 from then on.
- HOLD: DAC_CS stays low for CLKDIV cycles. At E0+65*CLKDIV:
  - DAC_CS=1;
  - dacdone=1 for exactly one cycle;
  - dac_datareceived updated with the received word;
  - go to GAP.
- GAP: busy stays high for CLKDIV cycles, guaranteeing minimum CS-high time. busy=0 after E0+66*CLKDIV, then IDLE.
- dactrig outside IDLE is ignored; it is neither queued nor counted. A level-high dactrig held across GAP starts a new frame on the first IDLE edge.
- Exactly 32 SCK rising edges per frame. SCK never toggles while DAC_CS=1.
- dac_datareceived holds its value between frames; it changes only at dacdone.
- RST mid-frame: on that edge, abort to the reset values above. No dacdone, dac_datareceived is cleared, and the partial frame is discarded.
- Half-period counter width is 8 bits and it reloads at each SCK toggle. The bit counter is 5 bits plus terminal detect; no wrap into a 33rd bit.

Optional Feature:
DAC_SPI_READBACK_EN
- Defined: SPI_MISO is sampled as described, and dac_datareceived reports the received word.
- Undefined: no receive shift register. dac_datareceived is constant 32'h0, SPI_MISO is unused, and all other timing is identical.

Decomposition:
- Shared package dac_pkg:
  - DAC_WORD_W=32, DAC_DATA_W=12;
  - command constants CMD_WRITE=4'b0000, CMD_UPDATE=4'b0001, CMD_WRITE_UPDATE=4'b0011, CMD_PWRDN=4'b0100;
  - address constants ADDR_A..ADDR_D, ADDR_ALL=4'b1111;
  - field bit positions for command/address/data in the word.
- One natural sub-module: spi_sck_gen. It holds the CLKDIV half-period counter plus enable, and emits one-cycle rise_tick/fall_tick strobes and the registered SCK. The FSM and shift registers stay in dac_spi_master.

Test Plan:
- CLKDIV=2; reset, then dactrig pulse with data=12'hABC, address=4'hF, command=4'h3 -> MOSI bits at 32 SCK rises equal 32'h003FABC0; CS low 130 cycles; dacdone at E0+130; busy low after E0+132.
- Model echoes the previous frame on MISO; send 12'h123 then 12'h456 -> second frame's dac_datareceived = 32'h003F1230 (READBACK_EN), 32'h0 when the macro is undefined.
- dactrig pulsed at E0+10 and E0+131 during a frame -> ignored; exactly one frame, one dacdone, 32 SCK rises.
- dactrig held high 400 cycles -> back-to-back frames with CS high ≥2 cycles between frames; one dacdone per frame.
- RST asserted at E0+50 -> next edge CS=1, SCK=0, MOSI=0, busy=0, dac_datareceived=0; no dacdone; a new trigger after reset produces a full correct frame.
- CLKDIV=1 and CLKDIV=255 -> SCK half-period exactly 1 and 255 cycles; dacdone at E0+65 and E0+16575 respectively.
